// File: rtl/sr_serial_rx_if.sv
// rtl/sr_serial_rx_if.sv - Three-wire serial LED link pins (ser_clk/ser_data/ser_latch).
interface sr_serial_rx_if;
  logic ser_clk;
  logic ser_data;
  logic ser_latch;

  modport master (output ser_clk, output ser_data, output ser_latch);
  modport slave  (input  ser_clk, input  ser_data, input  ser_latch);
endinterface

// File: rtl/sr_serial_rx.sv
// rtl/sr_serial_rx.sv - Serial LED link receiver: synchronize, deserialize MSB-first, latch to Led.
// Optional odd-parity frame bit enabled by defining SR_RX_PARITY_EN.
module sr_serial_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  sr_serial_rx_if.slave    link,
  output logic [WIDTH-1:0] Led,
  output logic             byte_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

`ifdef SR_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N  = WIDTH + P;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] N_V   = CW'(N);
  localparam logic [CW-1:0] SAT_V = CW'(N + 1);
  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM_V = WW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_clk_s;
  logic [SYNC_STAGES-1:0] r_dat_s;
  logic [SYNC_STAGES-1:0] r_lat_s;
  logic                   r_clk_p;
  logic                   r_lat_p;
  logic [WW-1:0]          r_warm;
  logic [N-1:0]           r_shift;
  logic [CW-1:0]          r_cnt;

  logic                   w_live;
  logic                   w_clk_rise;
  logic                   w_lat_rise;
  logic [N-1:0]           w_shift_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [WIDTH-1:0]       w_data;
  logic                   w_par_ok;

  // Edges only count once the prev flop holds a real post-reset sample,
  // so a pin held high through reset never looks like a fresh rise.
  assign w_live     = (r_warm == WARM_V);
  assign w_clk_rise = r_clk_s[SYNC_STAGES-1] & ~r_clk_p & w_live;
  assign w_lat_rise = r_lat_s[SYNC_STAGES-1] & ~r_lat_p & w_live;

  // Latch decisions use the post-shift view so a coincident bit is included.
  assign w_shift_nxt = w_clk_rise ? {r_shift[N-2:0], r_dat_s[SYNC_STAGES-1]} : r_shift;
  assign w_cnt_nxt   = (w_clk_rise && (r_cnt != SAT_V)) ? r_cnt + CW'(1) : r_cnt;
  assign w_data      = w_shift_nxt[WIDTH-1+P:P];

`ifdef SR_RX_PARITY_EN
  logic r_parity_err;
  assign w_par_ok   = ^w_shift_nxt;
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_clk_s    <= '0;
      r_dat_s    <= '0;
      r_lat_s    <= '0;
      r_clk_p    <= 1'b0;
      r_lat_p    <= 1'b0;
      r_warm     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      Led        <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef SR_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_clk_s    <= {r_clk_s[SYNC_STAGES-2:0], link.ser_clk};
      r_dat_s    <= {r_dat_s[SYNC_STAGES-2:0], link.ser_data};
      r_lat_s    <= {r_lat_s[SYNC_STAGES-2:0], link.ser_latch};
      r_clk_p    <= r_clk_s[SYNC_STAGES-1];
      r_lat_p    <= r_lat_s[SYNC_STAGES-1];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SR_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (!w_live) begin
        r_warm <= r_warm + WW'(1);
      end
      r_shift <= w_shift_nxt;
      if (w_lat_rise) begin
        r_cnt <= '0;
        busy  <= 1'b0;
        if (w_cnt_nxt != N_V) begin
          frame_err <= 1'b1;
        end else if (w_par_ok) begin
          Led        <= w_data;
          byte_valid <= 1'b1;
        end
`ifdef SR_RX_PARITY_EN
        else begin
          r_parity_err <= 1'b1;
        end
`endif
      end else begin
        r_cnt <= w_cnt_nxt;
        busy  <= (w_cnt_nxt != '0);
      end
    end
  end

endmodule

// File: tb/tb_sr_serial_rx.sv
// tb/tb_sr_serial_rx.sv - Scoreboard bench for sr_serial_rx with random frames and a bit-list reference model.
module tb_sr_serial_rx;
  localparam int W = 8;
  localparam int S = 2;
`ifdef SR_RX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  typedef struct {
    int          kind;   // 0 valid, 1 frame error, 2 parity error
    logic [W-1:0] led;
    longint      at;
  } exp_t;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] Led;
  logic         byte_valid, frame_err, parity_err, busy;

  sr_serial_rx_if link ();

  sr_serial_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .link       (link),
    .Led        (Led),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  bit model_bits[$];
  logic [W-1:0] model_led = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reference: a frame is its list of received bits; count, data and parity follow directly.
  task automatic model_latch(output exp_t e);
    int ones;
    logic [W-1:0] d;
    e.led = model_led;
    e.at  = cyc + S + 1;
    if (model_bits.size() != N) begin
      e.kind = 1;
    end else begin
      d = '0;
      ones = 0;
      for (int i = 0; i < W; i++) d = {d[W-2:0], model_bits[i]};
      foreach (model_bits[i]) ones += model_bits[i];
`ifdef SR_RX_PARITY_EN
      e.kind = (ones % 2 == 1) ? 0 : 2;
`else
      e.kind = 0;
`endif
      if (e.kind == 0) begin
        model_led = d;
        e.led = d;
      end
    end
  endtask

  task automatic send_bit(input bit b);
    link.ser_data = b;
    wait_clk(4);
    link.ser_clk = 1'b1;
    model_bits.push_back(b);
    wait_clk(4);
    check("busy_mid_frame", busy, 1);
    link.ser_clk = 1'b0;
    wait_clk(4);
  endtask

  task automatic do_latch(input bit with_clk, input bit b);
    exp_t e;
    if (with_clk) begin
      link.ser_data = b;
      wait_clk(4);
      model_bits.push_back(b);
    end
    model_latch(e);
    sb.push_back(e);
    link.ser_latch = 1'b1;
    if (with_clk) link.ser_clk = 1'b1;
    wait_clk(4);
    link.ser_latch = 1'b0;
    link.ser_clk = 1'b0;
    wait_clk(4);
    model_bits.delete();
    for (int i = 0; i < 20 && sb.size() != 0; i++) wait_clk(1);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    check("busy_after_latch", busy, 0);
  endtask

  task automatic send_bits(input bit bits[$], input bit coincide);
    int n;
    n = bits.size();
    if (coincide && n > 0) begin
      for (int i = 0; i < n - 1; i++) send_bit(bits[i]);
      do_latch(1'b1, bits[n-1]);
    end else begin
      for (int i = 0; i < n; i++) send_bit(bits[i]);
      do_latch(1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit coincide, input bit bad_par);
    bit bits[$];
    bit p;
    p = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
`ifdef SR_RX_PARITY_EN
    bits.push_back(p ^ bad_par);
`else
    p = bad_par;
`endif
    send_bits(bits, coincide);
  endtask

  task automatic send_random(input int n, input bit coincide);
    bit bits[$];
    for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
    send_bits(bits, coincide);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    model_bits.delete();
    model_led = '0;
    wait_clk(1);
    check("reset_led", Led, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {byte_valid, frame_err, parity_err}, 0);
  endtask

  int pulses;
  bit prev_pulse = 1'b0;
  logic [W-1:0] prev_led = '0;
  exp_t got;
  int kind;

  always @(negedge CLK) begin
    pulses = int'(byte_valid) + int'(frame_err) + int'(parity_err);
    if (reset) begin
      if (pulses != 0) begin
        check("pulse_count", pulses, 1);
        check("pulse_width", prev_pulse, 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=%0b%0b%0b required=none at cycle %0d",
                   byte_valid, frame_err, parity_err, cyc);
        end else begin
          got = sb.pop_front();
          kind = byte_valid ? 0 : (frame_err ? 1 : 2);
          check("pulse_kind", kind, got.kind);
          check("pulse_latency", cyc, got.at);
          check("led_value", Led, got.led);
        end
      end else begin
        check("led_stable", Led, prev_led);
      end
    end
    prev_led = Led;
    prev_pulse = (pulses != 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    link.ser_clk = 1'b0;
    link.ser_data = 1'b0;
    link.ser_latch = 1'b0;
    do_reset();
    wait_clk(6);

    send_frame(8'hA5, 1'b0, 1'b0);
    send_random(N - 1, 1'b0);
    send_random(N + 1, 1'b0);
    do_latch(1'b0, 1'b0);

    send_random(4, 1'b0);
    do_reset();
    wait_clk(6);
    send_frame(8'h3C, 1'b0, 1'b0);

    send_frame(8'hFF, 1'b1, 1'b0);

`ifdef SR_RX_PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
`endif

    link.ser_clk = 1'b1;
    do_reset();
    wait_clk(10);
    link.ser_clk = 1'b0;
    wait_clk(6);
    check("no_edge_from_held_pin", busy, 0);
    send_frame(8'h5A, 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int n;
      n = ($urandom_range(0, 9) < 6) ? N : int'($urandom_range(0, N + 2));
      if (n == N && $urandom_range(0, 3) == 0) begin
        send_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        send_random(n, (n > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
